lsu_unit: RTL

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the execute stage and a simple req/ack bus.
// Accepts one access per start pulse, checks alignment, issues one bus
// transaction, and returns an aligned/extended load result with a one-cycle
// done pulse. Misaligned accesses and bus timeouts complete with err=1.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start, is_store          request pulse and direction, sampled in IDLE
//   mem_ctrl, addr, wdata    funct3 access type, byte address, store data
//   rdata, done, err, busy   load result, completion pulse, error, stall
//   bus_req, bus_we          bus request and write enable
//   bus_addr, bus_be         word address and byte enables
//   bus_wdata                lane-replicated store data
//   bus_ack, bus_rdata       one-cycle acknowledge and read word
module lsu_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  mem_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t             state_q, state_d;
   size_t              size_q, size_d;
   logic               uns_q, uns_d;
   logic               store_q, store_d;
   logic [1:0]         off_q, off_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic [31:0]        rdata_q, rdata_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               bus_req_q, bus_req_d;
   logic               bus_we_q, bus_we_d;
   logic [31:0]        bus_addr_q, bus_addr_d;
   logic [3:0]         bus_be_q, bus_be_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;

   size_t              req_size_c;
   logic               req_uns_c;
   logic               misaligned_c;
   logic [3:0]         req_be_c;
   logic [31:0]        req_wdata_c;
   logic [7:0]         ld_byte_c;
   logic [15:0]        ld_half_c;
   logic [31:0]        ld_data_c;

   // Decode the incoming request; BU/HWU are load-only, anything else is a word.
   always_comb begin
      req_size_c = SZ_W;
      req_uns_c  = 1'b0;
      case (mem_ctrl)
         3'd0: req_size_c = SZ_B;
         3'd1: req_size_c = SZ_H;
         3'd4: if (!is_store) begin req_size_c = SZ_B; req_uns_c = 1'b1; end
         3'd5: if (!is_store) begin req_size_c = SZ_H; req_uns_c = 1'b1; end
         default: ;
      endcase
      misaligned_c = ((req_size_c == SZ_H) && addr[0]) ||
                     ((req_size_c == SZ_W) && (addr[1:0] != 2'b00));
      case (req_size_c)
         SZ_B: begin
            req_be_c    = 4'(4'b0001 << addr[1:0]);
            req_wdata_c = {4{wdata[7:0]}};
         end
         SZ_H: begin
            req_be_c    = 4'(4'b0011 << addr[1:0]);
            req_wdata_c = {2{wdata[15:0]}};
         end
         default: begin
            req_be_c    = 4'hF;
            req_wdata_c = wdata;
         end
      endcase
   end

   // Extract and extend the load lane from the returned bus word.
   always_comb begin
      ld_byte_c = bus_rdata[8*off_q +: 8];
      ld_half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size_q)
         SZ_B:    ld_data_c = {{24{~uns_q & ld_byte_c[7]}}, ld_byte_c};
         SZ_H:    ld_data_c = {{16{~uns_q & ld_half_c[15]}}, ld_half_c};
         default: ld_data_c = bus_rdata;
      endcase
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      uns_d       = uns_q;
      store_d     = store_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      rdata_d     = 32'h0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      busy_d      = 1'b0;
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               size_d  = req_size_c;
               uns_d   = req_uns_c;
               store_d = is_store;
               off_d   = addr[1:0];
               busy_d  = 1'b1;
               if (misaligned_c) begin
                  state_d = ST_RESP;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = '0;
                  bus_req_d   = 1'b1;
                  bus_we_d    = is_store;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = req_be_c;
                  bus_wdata_d = req_wdata_c;
               end
            end
         end
         ST_REQ: begin
            busy_d = 1'b1;
            if (bus_ack) begin
               state_d = ST_RESP;
               done_d  = 1'b1;
               rdata_d = store_q ? 32'h0 : ld_data_c;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               // Give up: bus_req drops together with the error completion.
               state_d = ST_RESP;
               cnt_d   = cnt_inc;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               cnt_d     = cnt_inc;
               bus_req_d = 1'b1;
               bus_we_d  = store_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         store_q     <= 1'b0;
         off_q       <= 2'b00;
         cnt_q       <= '0;
         rdata_q     <= 32'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         store_q     <= store_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule
